// File: rtl/sorting_pkg.sv
// -----------------------------------------------------------------------------
// sorting_pkg
// Shared types for the packet sorter.
//   state_e      : top-level controller state (IDLE, LOAD, SORT, OUT)
//   sort_phase_e : sub-phase of one bubble pass inside SORT
// -----------------------------------------------------------------------------
package sorting_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SORT,
        OUT
    } state_e;

    // One bubble pass is: SP_START (issue reads of words 0 and 1),
    // SP_STEP x (count-1) (compare/write one word per cycle),
    // SP_LAST (write the value that bubbled to the top of the pass).
    typedef enum logic [1:0] {
        SP_START,
        SP_STEP,
        SP_LAST
    } sort_phase_e;

endpackage : sorting_pkg

// File: rtl/sorting_ram.sv
// -----------------------------------------------------------------------------
// sorting_ram
// 2^AWIDTH x DWIDTH storage with one write port and two synchronous read
// ports (1-cycle read latency). A read of the address being written in the
// same cycle returns the old contents.
//   clk_i      : clock
//   we_i       : write enable
//   waddr_i    : write address
//   wdata_i    : write data
//   raddr_a_i  : read port A address  -> rdata_a_o one cycle later
//   raddr_b_i  : read port B address  -> rdata_b_o one cycle later
// -----------------------------------------------------------------------------
module sorting_ram #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 9
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AWIDTH-1:0] raddr_a_i,
    output logic [DWIDTH-1:0] rdata_a_o,
    input  logic [AWIDTH-1:0] raddr_b_i,
    output logic [DWIDTH-1:0] rdata_b_o
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset so it maps onto a block RAM; contents
    // survive srst_i and every word is written before it is read back.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_a_o <= mem_q[raddr_a_i];
        rdata_b_o <= mem_q[raddr_b_i];
    end

endmodule : sorting_ram

// File: rtl/sorting.sv
// -----------------------------------------------------------------------------
// sorting
// Streaming packet sorter. Loads one sop/eop-framed packet of up to
// 2^AWIDTH unsigned words, bubble-sorts it in place, then emits it in
// ascending order as one contiguous sop/eop-framed burst.
//   clk_i   : clock, rising edge
//   srst_i  : asynchronous active-low reset
//   data_i  : input word            sop_i/eop_i : packet framing
//   val_i   : input word valid
//   data_o  : sorted output word    sop_o/eop_o : output framing
//   val_o   : output word valid
//   busy_o  : high in SORT and OUT; input is ignored while high
// -----------------------------------------------------------------------------
module sorting
    import sorting_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 9
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              sop_i,
    input  logic              eop_i,
    input  logic              val_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              val_o,
    output logic              busy_o
);

    localparam int CW = AWIDTH + 1;

    typedef logic [CW-1:0]     cnt_t;
    typedef logic [AWIDTH-1:0] addr_t;
    typedef logic [DWIDTH-1:0] word_t;

    localparam cnt_t C_ONE  = cnt_t'(1);
    localparam cnt_t C_TWO  = cnt_t'(2);
    localparam cnt_t C_FULL = cnt_t'(1 << AWIDTH);

    // Controller state
    state_e      state_q;
    sort_phase_e sph_q;
    cnt_t        count_q;      // words stored in the current packet
    cnt_t        k_q;          // address written by the current sort step
    cnt_t        pass_q;       // completed bubble passes
    word_t       carry_q;      // largest value seen so far in this pass
    logic        swapped_q;    // this pass has moved at least one word
    cnt_t        rd_ptr_q;     // next address read in OUT

    // OUT read pipeline: rd_a holds a valid word when out_pv_q is set
    logic        out_pv_q;
    logic        out_first_q;
    logic        out_last_q;

    // Registered outputs
    word_t       data_o_q;
    logic        sop_o_q;
    logic        eop_o_q;
    logic        val_o_q;

    // RAM interface
    logic        ram_we;
    addr_t       ram_waddr;
    word_t       ram_wdata;
    addr_t       ram_raddr_a;
    addr_t       ram_raddr_b;
    word_t       rd_a;
    word_t       rd_b;

    // Sort datapath
    word_t       cur;
    logic        do_swap;
    cnt_t        k_plus2;
    cnt_t        last_idx;
    cnt_t        step_last;
    cnt_t        pass_next;

    sorting_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk_i     (clk_i),
        .we_i      (ram_we),
        .waddr_i   (ram_waddr),
        .wdata_i   (ram_wdata),
        .raddr_a_i (ram_raddr_a),
        .rdata_a_o (rd_a),
        .raddr_b_i (ram_raddr_b),
        .rdata_b_o (rd_b)
    );

    // The sort uses a single write per step: the larger of the pair is
    // carried forward in carry_q instead of being written back, and the
    // smaller is written at address k. This is the same compare/swap
    // sequence as a two-write bubble step, one word per cycle.
    //
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of latches.
    always_comb begin
        ram_we      = 1'b0;
        ram_waddr   = '0;
        ram_wdata   = data_i;
        ram_raddr_a = '0;
        ram_raddr_b = '0;

        // Step 0 takes mem[0] straight from port B; later steps use the carry.
        cur       = (k_q == '0) ? rd_b : carry_q;
        do_swap   = cur > rd_a;
        k_plus2   = k_q + C_TWO;
        last_idx  = count_q - C_ONE;
        step_last = count_q - C_TWO;
        pass_next = pass_q + C_ONE;

        unique case (state_q)
            IDLE: begin
                if (val_i && sop_i) begin
                    ram_we    = 1'b1;
                    ram_waddr = '0;
                end
            end
            LOAD: begin
                if (val_i) begin
                    if (sop_i) begin
                        ram_we    = 1'b1;
                        ram_waddr = '0;
                    end else if (count_q < C_FULL) begin
                        ram_we    = 1'b1;
                        ram_waddr = count_q[AWIDTH-1:0];
                    end
                end
            end
            SORT: begin
                unique case (sph_q)
                    SP_START: begin
                        ram_raddr_a = addr_t'(1);
                        ram_raddr_b = '0;
                    end
                    SP_STEP: begin
                        ram_we      = 1'b1;
                        ram_waddr   = k_q[AWIDTH-1:0];
                        ram_wdata   = do_swap ? rd_a : cur;
                        // Pre-read the next neighbour; past the end it wraps
                        // to a harmless address that is never used.
                        ram_raddr_a = k_plus2[AWIDTH-1:0];
                    end
                    SP_LAST: begin
                        ram_we    = 1'b1;
                        ram_waddr = last_idx[AWIDTH-1:0];
                        ram_wdata = carry_q;
                    end
                    default: begin
                    end
                endcase
            end
            OUT: begin
                ram_raddr_a = rd_ptr_q[AWIDTH-1:0];
            end
            default: begin
            end
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            state_q     <= IDLE;
            sph_q       <= SP_START;
            count_q     <= '0;
            k_q         <= '0;
            pass_q      <= '0;
            carry_q     <= '0;
            swapped_q   <= 1'b0;
            rd_ptr_q    <= '0;
            out_pv_q    <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            data_o_q    <= '0;
            sop_o_q     <= 1'b0;
            eop_o_q     <= 1'b0;
            val_o_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sph_q  <= SP_START;
                    pass_q <= '0;
                    if (val_i && sop_i) begin
                        count_q <= C_ONE;
                        state_q <= eop_i ? SORT : LOAD;
                    end
                end

                LOAD: begin
                    sph_q  <= SP_START;
                    pass_q <= '0;
                    if (val_i) begin
                        if (sop_i) begin
                            count_q <= C_ONE;
                        end else if (count_q < C_FULL) begin
                            count_q <= count_q + C_ONE;
                        end
                        // Overflow words are dropped but eop still ends it.
                        if (eop_i) begin
                            state_q <= SORT;
                        end
                    end
                end

                SORT: begin
                    unique case (sph_q)
                        SP_START: begin
                            if (count_q < C_TWO) begin
                                state_q  <= OUT;
                                rd_ptr_q <= '0;
                                out_pv_q <= 1'b0;
                            end else begin
                                k_q       <= '0;
                                swapped_q <= 1'b0;
                                sph_q     <= SP_STEP;
                            end
                        end
                        SP_STEP: begin
                            carry_q <= do_swap ? cur : rd_a;
                            if (do_swap) begin
                                swapped_q <= 1'b1;
                            end
                            if (k_q == step_last) begin
                                sph_q <= SP_LAST;
                            end else begin
                                k_q <= k_q + C_ONE;
                            end
                        end
                        SP_LAST: begin
                            pass_q <= pass_next;
                            if (!swapped_q || pass_next == last_idx) begin
                                state_q  <= OUT;
                                rd_ptr_q <= '0;
                                out_pv_q <= 1'b0;
                            end else begin
                                sph_q <= SP_START;
                            end
                        end
                        default: begin
                            sph_q <= SP_START;
                        end
                    endcase
                end

                OUT: begin
                    // Issue one read per cycle; the word reaches data_o two
                    // cycles after its address, so the burst is gap-free.
                    if (rd_ptr_q < count_q) begin
                        rd_ptr_q    <= rd_ptr_q + C_ONE;
                        out_pv_q    <= 1'b1;
                        out_first_q <= (rd_ptr_q == '0);
                        out_last_q  <= (rd_ptr_q == last_idx);
                    end else begin
                        out_pv_q <= 1'b0;
                    end

                    if (out_pv_q) begin
                        val_o_q  <= 1'b1;
                        data_o_q <= rd_a;
                        sop_o_q  <= out_first_q;
                        eop_o_q  <= out_last_q;
                    end else if (val_o_q && eop_o_q) begin
                        // Last word has been on the bus for one cycle.
                        val_o_q <= 1'b0;
                        sop_o_q <= 1'b0;
                        eop_o_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_o = data_o_q;
    assign sop_o  = sop_o_q;
    assign eop_o  = eop_o_q;
    assign val_o  = val_o_q;
    assign busy_o = (state_q == SORT) || (state_q == OUT);

endmodule : sorting

// File: tb/tb_sorting.sv
// -----------------------------------------------------------------------------
// tb_sorting
// Directed and random packets through the sorter, checked against a
// histogram-based reference sort.
// -----------------------------------------------------------------------------
module tb_sorting;

    localparam int DWIDTH = 8;
    localparam int AWIDTH = 9;
    localparam int DEPTH  = 1 << AWIDTH;
    localparam int NVAL   = 1 << DWIDTH;

    typedef logic [DWIDTH-1:0] word_t;
    typedef word_t word_q_t[$];

    logic  clk_i  = 1'b0;
    logic  srst_i = 1'b0;
    word_t data_i = '0;
    logic  sop_i  = 1'b0;
    logic  eop_i  = 1'b0;
    logic  val_i  = 1'b0;
    word_t data_o;
    logic  sop_o;
    logic  eop_o;
    logic  val_o;
    logic  busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    sorting #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) dut (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .data_i (data_i),
        .sop_i  (sop_i),
        .eop_i  (eop_i),
        .val_i  (val_i),
        .data_o (data_o),
        .sop_o  (sop_o),
        .eop_o  (eop_o),
        .val_o  (val_o),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: count occurrences of each value, then list values in
    // ascending order as many times as they occurred.
    function automatic word_q_t ref_sort(input word_q_t in);
        int      hist[NVAL];
        word_q_t res;
        for (int v = 0; v < NVAL; v++) hist[v] = 0;
        foreach (in[i]) hist[int'(in[i])]++;
        for (int v = 0; v < NVAL; v++) begin
            repeat (hist[v]) res.push_back(word_t'(v));
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input word_q_t pkt, input bit gaps);
        for (int i = 0; i < pkt.size(); i++) begin
            if (gaps && i > 0) begin
                val_i = 1'b0;
                sop_i = 1'b0;
                eop_i = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            data_i = pkt[i];
            val_i  = 1'b1;
            sop_i  = (i == 0);
            eop_i  = (i == pkt.size() - 1);
            tick();
        end
        val_i = 1'b0;
        sop_i = 1'b0;
        eop_i = 1'b0;
    endtask

    // Called one cycle after the eop edge. Waits (bounded) for the burst,
    // then checks every word and the framing, then the drop of val/busy.
    task automatic expect_out(input word_q_t exp, input string tag);
        int n      = exp.size();
        int budget = 2 * n * n + 12;
        int waited = 0;
        check($sformatf("%s busy_after_eop", tag), 32'(busy_o), 32'd1);
        while (val_o !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        check($sformatf("%s val_o_within_budget", tag), 32'(val_o), 32'd1);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s val[%0d]", tag, i), 32'(val_o), 32'd1);
            check($sformatf("%s data[%0d]", tag, i), 32'(data_o), 32'(exp[i]));
            check($sformatf("%s sop[%0d]", tag, i), 32'(sop_o), 32'(i == 0));
            check($sformatf("%s eop[%0d]", tag, i), 32'(eop_o), 32'(i == n - 1));
            tick();
        end
        check($sformatf("%s val_low_after", tag), 32'(val_o), 32'd0);
        check($sformatf("%s busy_low_after", tag), 32'(busy_o), 32'd0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        word_q_t pkt;
        word_q_t exp;
        word_q_t junk;
        word_t   t;
        int      j;
        int      len;
        int      waited;

        // Reset state
        #2;
        check("reset val_o", 32'(val_o), 32'd0);
        check("reset sop_o", 32'(sop_o), 32'd0);
        check("reset eop_o", 32'(eop_o), 32'd0);
        check("reset data_o", 32'(data_o), 32'd0);
        check("reset busy_o", 32'(busy_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        srst_i = 1'b1;
        tick();

        // 3-word packet
        pkt = '{8'h30, 8'h10, 8'h20};
        exp = '{8'h10, 8'h20, 8'h30};
        send(pkt, 1'b0);
        expect_out(exp, "three");

        // Duplicates and extremes
        pkt = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h7F};
        exp = '{8'h00, 8'h00, 8'h7F, 8'hFF, 8'hFF};
        send(pkt, 1'b0);
        expect_out(exp, "dups");

        // Single word
        pkt = '{8'hAA};
        exp = '{8'hAA};
        send(pkt, 1'b0);
        expect_out(exp, "single");

        // Full packet: random values with local disorder so the bubble
        // sort finishes in a few passes.
        pkt.delete();
        for (int i = 0; i < DEPTH; i++) pkt.push_back(word_t'($urandom_range(0, NVAL - 1)));
        pkt = ref_sort(pkt);
        repeat (30) begin
            j          = int'($urandom_range(0, DEPTH - 2));
            t          = pkt[j];
            pkt[j]     = pkt[j + 1];
            pkt[j + 1] = t;
        end
        send(pkt, 1'b0);
        expect_out(ref_sort(pkt), "full");

        // Overflow: two extra zero words beyond capacity must be dropped.
        pkt.delete();
        for (int i = 0; i < DEPTH; i++) pkt.push_back(word_t'($urandom_range(1, NVAL - 1)));
        pkt = ref_sort(pkt);
        repeat (20) begin
            j          = int'($urandom_range(0, DEPTH - 2));
            t          = pkt[j];
            pkt[j]     = pkt[j + 1];
            pkt[j + 1] = t;
        end
        exp = ref_sort(pkt);
        pkt.push_back(8'h00);
        pkt.push_back(8'h00);
        send(pkt, 1'b0);
        expect_out(exp, "overflow");

        // Back-to-back random packets, each sop sent as soon as busy drops.
        for (int p = 0; p < 40; p++) begin
            len = int'($urandom_range(3, 24));
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(word_t'($urandom_range(0, NVAL - 1)));
            send(pkt, p[0]);
            expect_out(ref_sort(pkt), $sformatf("rand%0d", p));
        end

        // A packet offered while busy must be ignored.
        pkt  = '{8'h40, 8'h30, 8'h20, 8'h10};
        junk = '{8'h01, 8'h02, 8'h03};
        send(pkt, 1'b0);
        check("busy before junk", 32'(busy_o), 32'd1);
        send(junk, 1'b0);
        expect_out(ref_sort(pkt), "busy_ignore");

        // Reset in the middle of OUT
        pkt = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        send(pkt, 1'b0);
        waited = 0;
        while (val_o !== 1'b1 && waited < 2 * 64 + 12) begin
            tick();
            waited++;
        end
        check("midreset reached OUT", 32'(val_o), 32'd1);
        tick();
        srst_i = 1'b0;
        #1;
        check("midreset val_o", 32'(val_o), 32'd0);
        check("midreset sop_o", 32'(sop_o), 32'd0);
        check("midreset eop_o", 32'(eop_o), 32'd0);
        check("midreset data_o", 32'(data_o), 32'd0);
        check("midreset busy_o", 32'(busy_o), 32'd0);
        tick();
        tick();
        srst_i = 1'b1;
        tick();

        // Packet after reset
        pkt = '{8'h5A, 8'hC3, 8'h00, 8'h5A, 8'h11, 8'hFE};
        send(pkt, 1'b1);
        expect_out(ref_sort(pkt), "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_sorting
